// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: FSM encoding and ALUControl limits shared by the arbiter files
package alu_share_arb_pkg;

    localparam int CTRL_W_DEF = 4;
    localparam logic [3:0] CTRL_MAX = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant with its own last_grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    // on contention the requester not granted last wins
    always_comb begin
        gnt = !en ? 2'b00 : (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|gnt)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external ALU between two requesters, one operation in flight at a time
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);

    state_t state, state_nx;
    logic [1:0] gnt;
    logic op_id;
    logic err;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == IDLE && !rst),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign busy       = state != IDLE && !rst;
    assign err        = alu_ctrl > CTRL_W'(CTRL_MAX);

    always_comb begin
        state_nx = state == IDLE ? (|gnt ? EXEC : IDLE) :
                   state == EXEC ? RESP :
                   rsp_ready     ? IDLE : RESP;
    end

    // alu_* are the operand registers themselves, so the ALU never sees live request inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (|gnt) begin
                alu_a    <= gnt[1] ? req1_a : req0_a;
                alu_b    <= gnt[1] ? req1_b : req0_b;
                alu_ctrl <= gnt[1] ? req1_ctrl : req0_ctrl;
                op_id    <= gnt[1];
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= op_id;
                rsp_result <= err ? '0 : alu_result;
                rsp_zero   <= !err && alu_zero;
                rsp_err    <= err;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
